// File: rtl/cim_fp_pkg.sv
// cim_fp_pkg: shared types and constants for the CIM accumulator-to-float converter
package cim_fp_pkg;
    localparam int CIM_N_CH      = 4;
    localparam int CIM_ACC_W     = 18;
    localparam int CIM_EXP_W     = 5;
    localparam int CIM_MANT_W    = 3;
    localparam int CIM_FRAC_BITS = 5;

    typedef enum logic {RND_TRUNC = 1'b0, RND_RNE = 1'b1} rnd_mode_t;

    typedef struct packed {
        logic                  sign;
        logic [CIM_EXP_W-1:0]  exp;
        logic [CIM_MANT_W-1:0] mant;
    } fp_lane_t;

    // largest exponent that still encodes a finite value; all-ones is reserved for saturation
    function automatic int exp_max_finite(input int exp_w);
        return (1 << exp_w) - 2;
    endfunction

    localparam int EXP_MAX_FINITE = exp_max_finite(CIM_EXP_W);
endpackage

// File: rtl/cim_fp_lane_norm.sv
// cim_fp_lane_norm: one lane of the capture / leading-one-align / round-and-pack datapath
module cim_fp_lane_norm
    import cim_fp_pkg::*;
#(
    parameter int ACC_W     = CIM_ACC_W,
    parameter int EXP_W     = CIM_EXP_W,
    parameter int MANT_W    = CIM_MANT_W,
    parameter int FRAC_BITS = CIM_FRAC_BITS
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              en,
    input  logic              in_fp,
    input  logic              sign_in,
    input  logic [ACC_W-1:0]  acc,
    input  logic              s2_fp,
    input  rnd_mode_t         s2_rnd,
    input  logic [EXP_W-1:0]  s2_exp_max,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mant_out,
    output logic [ACC_W-1:0]  int_out,
    output logic              zero_flag,
    output logic              ovf_flag,
    output logic              udf_flag
);
    localparam int PW    = $clog2(ACC_W);
    localparam int EW    = EXP_W + 2;
    localparam int E_TOP = exp_max_finite(EXP_W);

    logic [ACC_W-1:0]     a1, raw1, raw2;
    logic                 sg1, sg2, g2, st2, z2;
    logic [PW-1:0]        msb, pos2;
    logic [ACC_W-2:0]     aligned;
    logic [MANT_W-1:0]    m2;
    logic [MANT_W:0]      m_rnd;
    logic signed [EW-1:0] e_raw;
    logic                 fz, udf_c, ovf_c;

    // S1: magnitude (ACC_W bits so the most negative value fits) and effective sign
    always_ff @(posedge clk or posedge RST)
        if (RST) begin
            a1   <= '0;
            raw1 <= '0;
            sg1  <= 1'b0;
        end else if (en) begin
            a1   <= acc[ACC_W-1] ? -acc : acc;
            raw1 <= acc;
            sg1  <= acc[ACC_W-1] ^ (in_fp & sign_in);
        end

    // leading-one detect and left alignment; the leading one itself is shifted out
    always_comb begin
        msb = '0;
        for (int i = 0; i < ACC_W; i++)
            if (a1[i]) msb = PW'(i);
        aligned = (ACC_W-1)'(a1 << (PW'(ACC_W - 1) - msb));
    end

    // S2: mantissa field, guard and sticky below the leading one
    always_ff @(posedge clk or posedge RST)
        if (RST) begin
            pos2 <= '0;
            m2   <= '0;
            g2   <= 1'b0;
            st2  <= 1'b0;
            z2   <= 1'b0;
            sg2  <= 1'b0;
            raw2 <= '0;
        end else if (en) begin
            pos2 <= msb;
            m2   <= aligned[ACC_W-2 -: MANT_W];
            g2   <= aligned[ACC_W-2-MANT_W];
            st2  <= |aligned[ACC_W-3-MANT_W:0];
            z2   <= ~|a1;
            sg2  <= sg1;
            raw2 <= raw1;
        end

    // rounding, exponent with carry-in, and range classification
    always_comb begin
        m_rnd = {1'b0, m2} + {{MANT_W{1'b0}}, s2_rnd == RND_RNE && g2 && (st2 || m2[0])};
        e_raw = EW'(s2_exp_max) + EW'(pos2) - EW'(FRAC_BITS) + EW'(m_rnd[MANT_W]);
        fz    = ~s2_fp | z2;
        udf_c = ~fz && e_raw < 1;
        ovf_c = ~fz && e_raw > E_TOP;
    end

    // S3: packed result registers driving the lane outputs
    always_ff @(posedge clk or posedge RST)
        if (RST) begin
            sign_out  <= 1'b0;
            exp_out   <= '0;
            mant_out  <= '0;
            int_out   <= '0;
            zero_flag <= 1'b0;
            ovf_flag  <= 1'b0;
            udf_flag  <= 1'b0;
        end else if (en) begin
            sign_out  <= sg2;
            exp_out   <= (fz || udf_c) ? '0 : ovf_c ? '1 : e_raw[EXP_W-1:0];
            mant_out  <= (fz || udf_c || ovf_c) ? '0 : m_rnd[MANT_W-1:0];
            int_out   <= s2_fp ? '0 : raw2;
            zero_flag <= s2_fp & z2;
            ovf_flag  <= ovf_c;
            udf_flag  <= udf_c;
        end
endmodule

// File: rtl/cim_fp_normalizer.sv
// cim_fp_normalizer: 3-stage accumulator-to-float converter with valid/ready back-pressure
module cim_fp_normalizer
    import cim_fp_pkg::*;
#(
    parameter int N_CH      = CIM_N_CH,
    parameter int ACC_W     = CIM_ACC_W,
    parameter int EXP_W     = CIM_EXP_W,
    parameter int MANT_W    = CIM_MANT_W,
    parameter int FRAC_BITS = CIM_FRAC_BITS
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_fp,
    input  logic                     rnd_mode,
    input  logic [EXP_W-1:0]         exp_max,
    input  logic [N_CH-1:0]          sign_in,
    input  logic [N_CH*ACC_W-1:0]    acc_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_fp,
    output logic [N_CH-1:0]          sign_out,
    output logic [N_CH*EXP_W-1:0]    exp_out,
    output logic [N_CH*MANT_W-1:0]   mant_out,
    output logic [N_CH*ACC_W-1:0]    int_out,
    output logic [N_CH-1:0]          zero_flag,
    output logic [N_CH-1:0]          ovf_flag,
    output logic [N_CH-1:0]          udf_flag
);
    logic             en, v1, v2, fp1, fp2;
    rnd_mode_t        rnd1, rnd2;
    logic [EXP_W-1:0] em1, em2;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // valid chain and per-transaction controls advance together on one global enable
    always_ff @(posedge clk or posedge RST)
        if (RST) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            fp1       <= 1'b0;
            fp2       <= 1'b0;
            out_fp    <= 1'b0;
            rnd1      <= RND_TRUNC;
            rnd2      <= RND_TRUNC;
            em1       <= '0;
            em2       <= '0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            fp1       <= in_fp;
            fp2       <= fp1;
            out_fp    <= fp2;
            rnd1      <= rnd_mode_t'(rnd_mode);
            rnd2      <= rnd1;
            em1       <= exp_max;
            em2       <= em1;
        end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        cim_fp_lane_norm #(
            .ACC_W(ACC_W), .EXP_W(EXP_W), .MANT_W(MANT_W), .FRAC_BITS(FRAC_BITS)
        ) u_lane (
            .clk       (clk),
            .RST       (RST),
            .en        (en),
            .in_fp     (in_fp),
            .sign_in   (sign_in[k]),
            .acc       (acc_in[k*ACC_W +: ACC_W]),
            .s2_fp     (fp2),
            .s2_rnd    (rnd2),
            .s2_exp_max(em2),
            .sign_out  (sign_out[k]),
            .exp_out   (exp_out[k*EXP_W +: EXP_W]),
            .mant_out  (mant_out[k*MANT_W +: MANT_W]),
            .int_out   (int_out[k*ACC_W +: ACC_W]),
            .zero_flag (zero_flag[k]),
            .ovf_flag  (ovf_flag[k]),
            .udf_flag  (udf_flag[k])
        );
    end
endmodule

// File: tb/tb_cim_fp_normalizer.sv
// tb_cim_fp_normalizer: directed and randomized checks of cim_fp_normalizer against an arithmetic model
module tb_cim_fp_normalizer;
    import cim_fp_pkg::*;

    localparam int N  = CIM_N_CH;
    localparam int AW = CIM_ACC_W;
    localparam int EW = CIM_EXP_W;
    localparam int MW = CIM_MANT_W;
    localparam int FB = CIM_FRAC_BITS;

    logic            clk = 1'b0;
    logic            RST;
    logic            in_valid, in_ready, in_fp, rnd_mode, out_valid, out_ready, out_fp;
    logic [EW-1:0]   exp_max;
    logic [N-1:0]    sign_in, sign_out, zero_flag, ovf_flag, udf_flag;
    logic [N*AW-1:0] acc_in, int_out;
    logic [N*EW-1:0] exp_out;
    logic [N*MW-1:0] mant_out;

    cim_fp_normalizer dut (
        .clk(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_fp(in_fp),
        .rnd_mode(rnd_mode), .exp_max(exp_max), .sign_in(sign_in), .acc_in(acc_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp), .sign_out(sign_out),
        .exp_out(exp_out), .mant_out(mant_out), .int_out(int_out), .zero_flag(zero_flag),
        .ovf_flag(ovf_flag), .udf_flag(udf_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            fp;
        logic [N-1:0]    sg, z, o, u;
        logic [N*EW-1:0] ex;
        logic [N*MW-1:0] mt;
        logic [N*AW-1:0] iv;
    } rec_t;

    rec_t         exq[$];
    int           checks = 0, failures = 0, n_acc = 0, n_out = 0;
    logic         stalled = 1'b0;
    logic [127:0] snap_prev = '0;
    logic [127:0] snap;

    assign snap = 128'({out_valid, out_fp, sign_out, exp_out, mant_out, int_out, zero_flag, ovf_flag, udf_flag});

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // value = mag * 2^(exp_max - FRAC_BITS); float = 2^e * q/2^MW with q in [2^MW, 2^(MW+1))
    function automatic void model_lane(input logic signed [AW-1:0] a, input logic si, f, r,
                                       input int em, output fp_lane_t l, output logic z, o, u);
        longint mag, den, q, rem;
        int p, e;
        z = 0; o = 0; u = 0;
        l.sign = a[AW-1] ^ (f & si);
        l.exp  = '0;
        l.mant = '0;
        if (!f) return;
        mag = (a < 0) ? -longint'(a) : longint'(a);
        if (mag == 0) begin z = 1; return; end
        p = 0;
        while ((longint'(1) << (p + 1)) <= mag) p++;
        den = longint'(1) << p;
        q   = (mag << MW) / den;
        rem = (mag << MW) % den;
        if (r && (2 * rem > den || (2 * rem == den && q[0]))) q++;
        e = em + p - FB;
        if (q == (longint'(2) << MW)) begin q = longint'(1) << MW; e++; end
        if (e < 1) u = 1;
        else if (e > (1 << EW) - 2) begin o = 1; l.exp = '1; end
        else begin l.exp = EW'(e); l.mant = MW'(q - (longint'(1) << MW)); end
    endfunction

    function automatic rec_t build();
        rec_t r;
        fp_lane_t l;
        logic z, o, u;
        r.fp = in_fp;
        r.iv = in_fp ? '0 : acc_in;
        for (int k = 0; k < N; k++) begin
            model_lane(acc_in[k*AW +: AW], sign_in[k], in_fp, rnd_mode, int'(exp_max), l, z, o, u);
            r.sg[k] = l.sign;
            r.ex[k*EW +: EW] = l.exp;
            r.mt[k*MW +: MW] = l.mant;
            r.z[k] = z; r.o[k] = o; r.u[k] = u;
        end
        return r;
    endfunction

    // scoreboard: push at accept, compare at each output handshake, watch stability while stalled
    always @(negedge clk) begin
        if (RST) stalled = 1'b0;
        else begin
            if (stalled) chk("stable", snap, snap_prev);
            stalled   = out_valid && !out_ready;
            snap_prev = snap;
            if (in_valid && in_ready) begin n_acc++; exq.push_back(build()); end
            if (out_valid && out_ready) begin
                if (exq.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    rec_t e;
                    e = exq.pop_front();
                    n_out++;
                    chk("sb_fp", out_fp, e.fp);
                    chk("sb_sign", sign_out, e.sg);
                    chk("sb_exp", exp_out, e.ex);
                    chk("sb_mant", mant_out, e.mt);
                    chk("sb_int", int_out, e.iv);
                    chk("sb_flags", {zero_flag, ovf_flag, udf_flag}, {e.z, e.o, e.u});
                end
            end
        end
    end

    function automatic logic [AW-1:0] rand_acc();
        int w;
        logic [AW-1:0] v;
        w = $urandom_range(0, AW);
        v = AW'($urandom) & ((AW'(1) << w) - AW'(1));
        if ($urandom_range(0, 1) == 1) v = -v;
        if ($urandom_range(0, 15) == 0) v = {1'b1, {(AW-1){1'b0}}};
        return v;
    endfunction

    task automatic rand_in();
        for (int k = 0; k < N; k++) acc_in[k*AW +: AW] = rand_acc();
        sign_in  = N'($urandom);
        in_fp    = $urandom_range(0, 3) != 0;
        rnd_mode = 1'($urandom);
        exp_max  = EW'($urandom);
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic run_one(input string tag, input logic [AW-1:0] a, input logic si, f, r,
                           input logic [EW-1:0] em, input logic es, input logic [EW-1:0] ee,
                           input logic [MW-1:0] emt, input logic [2:0] fl, input logic [AW-1:0] ei);
        rand_in();
        acc_in[AW-1:0] = a;
        sign_in[0] = si;
        in_fp = f; rnd_mode = r; exp_max = em;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_sign"}, sign_out[0], es);
        chk({tag, "_exp"}, exp_out[EW-1:0], ee);
        chk({tag, "_mant"}, mant_out[MW-1:0], emt);
        chk({tag, "_flags"}, {zero_flag[0], ovf_flag[0], udf_flag[0]}, fl);
        chk({tag, "_int"}, int_out[AW-1:0], ei);
        @(posedge clk); #1;
    endtask

    initial begin
        RST = 1'b1; in_valid = 0; in_fp = 1; rnd_mode = 0; exp_max = 10;
        sign_in = 0; acc_in = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", snap, 0);
        RST = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", in_ready, 1);

        run_one("pos32",     AW'(32),      0, 1, 0, 10, 0, 10, 0, 3'b000, 0);
        run_one("neg48",     -AW'(48),     0, 1, 0, 10, 1, 10, 4, 3'b000, 0);
        run_one("neg48_si",  -AW'(48),     1, 1, 0, 10, 0, 10, 4, 3'b000, 0);
        run_one("r62_trunc", AW'(62),      0, 1, 0, 10, 0, 10, 7, 3'b000, 0);
        run_one("r62_rne",   AW'(62),      0, 1, 1, 10, 0, 11, 0, 3'b000, 0);
        run_one("zero",      AW'(0),       0, 1, 0, 10, 0, 0,  0, 3'b100, 0);
        run_one("ovf",       AW'(131071),  0, 1, 0, 31, 0, 31, 0, 3'b010, 0);
        run_one("udf",       AW'(1),       0, 1, 0, 2,  0, 0,  0, 3'b001, 0);
        run_one("min_neg",   AW'(131072),  0, 1, 0, 10, 1, 22, 0, 3'b000, 0);
        run_one("bypass",    -AW'(5),      1, 0, 1, 10, 1, 0,  0, 3'b000, -AW'(5));

        // back-pressure: 5 back-to-back inputs against a 6-cycle output stall
        begin
            int base_acc, base_out;
            repeat (4) @(posedge clk);
            #1;
            base_acc = n_acc;
            base_out = n_out;
            fork
                begin
                    for (int t = 0; t < 5; t++) begin
                        rand_in();
                        in_valid = 1'b1;
                        wait_accept();
                    end
                    in_valid = 1'b0;
                end
                begin
                    out_ready = 1'b0;
                    repeat (6) @(posedge clk);
                    #1 out_ready = 1'b1;
                end
                begin
                    bit seen = 0;
                    for (int i = 0; i < 20 && !seen; i++) begin
                        @(negedge clk);
                        if (!in_ready) begin
                            seen = 1;
                            chk("stall_accepts", 128'(n_acc - base_acc), 3);
                        end
                    end
                    chk("stall_seen", seen, 1);
                end
            join
            for (int i = 0; i < 20 && exq.size() != 0; i++) @(posedge clk);
            #1;
            chk("stall_outputs", 128'(n_out - base_out), 5);
        end

        // reset with three transactions in flight
        rand_in();
        in_fp = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        chk("pre_rst_vld", out_valid, 1);
        #1 RST = 1'b1;
        #1;
        chk("rst_vld", out_valid, 0);
        chk("rst_outs", snap, 0);
        exq.delete();
        repeat (2) @(posedge clk);
        #1 RST = 1'b0;
        @(posedge clk); #1;
        begin
            int n;
            acc_in = 0;
            acc_in[AW-1:0] = AW'(32);
            sign_in = 0; in_fp = 1; rnd_mode = 0; exp_max = 10;
            in_valid = 1'b1;
            @(posedge clk);
            n = 1;
            #1 in_valid = 1'b0;
            while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
            chk("post_rst_latency", 128'(n), 3);
            chk("post_rst_exp", exp_out[EW-1:0], 10);
            chk("post_rst_mant", mant_out[MW-1:0], 0);
            @(posedge clk); #1;
        end

        // randomized traffic with random gaps and random output stalls
        begin
            int sent = 0;
            bit acc_ok;
            for (int c = 0; c < 4000 && sent < 300; c++) begin
                if (!in_valid && $urandom_range(0, 3) != 0) begin rand_in(); in_valid = 1'b1; end
                out_ready = $urandom_range(0, 3) != 0;
                @(negedge clk);
                acc_ok = in_valid && in_ready;
                @(posedge clk);
                #1;
                if (acc_ok) begin sent++; in_valid = 1'b0; end
            end
            in_valid = 1'b0;
            chk("rand_sent", 128'(sent), 300);
            out_ready = 1'b1;
            for (int i = 0; i < 20 && exq.size() != 0; i++) @(posedge clk);
            #1;
            chk("drain_empty", 128'(exq.size()), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
